// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator: FSM encoding and default sizes.
package seq_gen_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_LW    = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/seq_gen_if.sv
// Pattern request / serial output bundle between a pattern source and seq_gen.
interface seq_gen_if
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LW    = DEF_LW
);
    logic             load;
    logic [WIDTH-1:0] data;
    logic [LW-1:0]    len;
    logic             repeat_en;
    logic             dout;
    logic             dout_vld;
    logic             busy;
    logic             done;

    modport master (
        output load, data, len, repeat_en,
        input  dout, dout_vld, busy, done
    );

    modport slave (
        input  load, data, len, repeat_en,
        output dout, dout_vld, busy, done
    );
endinterface

// File: rtl/seq_gen_shreg.sv
// WIDTH-bit parallel-load, shift-left register; msb is the serial output bit.
module seq_gen_shreg
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             sh,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= d;
        end else if (sh) begin
            r_q <= {r_q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = r_q[WIDTH-1];

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: sends the top len bits of a captured word MSB first,
// optionally repeating back-to-back, with a one-cycle done pulse at the end.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LW    = DEF_LW
) (
    input  logic     clk,
    input  logic     rst,
    seq_gen_if.slave bus
);

    seq_state_t       r_state;
    seq_state_t       w_nxt;
    logic [LW-1:0]    r_cnt;
    logic [LW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_word;
    logic [LW-1:0]    r_len;
    logic             r_vld;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic [LW-1:0]    w_eff_len;
    logic             w_ld;
    logic             w_sh;
    logic [WIDTH-1:0] w_d;
    logic             w_cap;
    logic             w_msb;

    assign w_eff_len = (bus.len > LW'(WIDTH)) ? LW'(WIDTH) : bus.len;
    assign w_accept  = bus.load && (bus.len != '0) &&
                       ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = r_cnt;
        w_ld      = 1'b0;
        w_sh      = 1'b0;
        w_d       = '0;
        w_cap     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_nxt = ST_IDLE;
                if (w_accept) begin
                    w_nxt     = ST_SHIFT;
                    w_ld      = 1'b1;
                    w_d       = bus.data;
                    w_cnt_nxt = w_eff_len;
                    w_cap     = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (r_cnt <= LW'(1)) begin
                    // Last bit on the wire: reload the word or clear the register so dout drops to 0.
                    w_ld = 1'b1;
                    if (bus.repeat_en) begin
                        w_d       = r_word;
                        w_cnt_nxt = r_len;
                    end else begin
                        w_nxt     = ST_DONE;
                        w_cnt_nxt = '0;
                    end
                end else begin
                    w_sh      = 1'b1;
                    w_cnt_nxt = r_cnt - LW'(1);
                end
            end
            default: begin
                w_nxt     = ST_IDLE;
                w_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_word  <= '0;
            r_len   <= '0;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
            r_vld   <= (w_nxt == ST_SHIFT);
            r_busy  <= (w_nxt == ST_SHIFT);
            r_done  <= (w_nxt == ST_DONE);
            if (w_cap) begin
                r_word <= bus.data;
                r_len  <= w_eff_len;
            end
        end
    end

    seq_gen_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk (clk),
        .rst (rst),
        .ld  (w_ld),
        .sh  (w_sh),
        .d   (w_d),
        .msb (w_msb)
    );

    assign bus.dout     = w_msb;
    assign bus.dout_vld = r_vld;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen with hand-computed bit streams and a 1011 detector on the serial output.
module tb_seq_gen;

    localparam logic [31:0] S_IDLE = 32'b0000;
    localparam logic [31:0] S_DONE = 32'b0010;

    logic clk;
    logic rst;
    int unsigned n_vec;
    int unsigned n_err;

    seq_gen_if #(.WIDTH(32), .LW(6)) bus ();

    seq_gen #(.WIDTH(32), .LW(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the sequence detector: flags an overlapping 1011 on valid bits.
    logic [3:0] det_hist;
    logic       det_flag;
    always @(posedge clk) begin
        if (rst) begin
            det_hist <= 4'b0;
            det_flag <= 1'b0;
        end else if (bus.dout_vld) begin
            det_hist <= {det_hist[2:0], bus.dout};
            det_flag <= ({det_hist[2:0], bus.dout} == 4'b1011);
        end else begin
            det_flag <= 1'b0;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] status();
        return {28'b0, bus.dout_vld, bus.busy, bus.done, bus.dout};
    endfunction

    // Loads a pattern and checks nexp valid bits (MSB-first in expbits), ending on the DONE cycle.
    task automatic send_and_check(input string tag, input logic [31:0] d, input logic [5:0] l,
                                  input int unsigned nexp, input logic [31:0] expbits,
                                  input bit poke, input bit det);
        logic [3:0] ref_hist;
        logic       ref_flag;
        logic       b;
        ref_hist = 4'b0;
        ref_flag = 1'b0;
        bus.load = 1'b1;
        bus.data = d;
        bus.len  = l;
        step();
        bus.load = 1'b0;
        for (int unsigned i = 0; i < nexp; i++) begin
            b = expbits[31-i];
            check_vec(tag, status(), {28'b0, 3'b110, b});
            if (det) check_vec({tag, "_det"}, 32'(det_flag), 32'(ref_flag));
            ref_flag = ({ref_hist[2:0], b} == 4'b1011);
            ref_hist = {ref_hist[2:0], b};
            if (poke && i == 5) begin
                bus.load = 1'b1;
                bus.data = '1;
                bus.len  = 6'd7;
            end
            if (poke && i == 6) bus.load = 1'b0;
            step();
        end
        check_vec({tag, "_done"}, status(), S_DONE);
        if (det) check_vec({tag, "_det_end"}, 32'(det_flag), 32'(ref_flag));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic b;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.load = 1'b0;
        bus.data = '0;
        bus.len = '0;
        bus.repeat_en = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_vec("reset", status(), S_IDLE);

        // Full-width pattern, also driving the detector loopback.
        send_and_check("p32", 32'h6DB4B255, 6'd32, 32,
                       32'b0110_1101_1011_0100_1011_0010_0101_0101, 1'b0, 1'b1);
        step();
        check_vec("p32_idle", status(), S_IDLE);

        // len=0 is ignored.
        bus.load = 1'b1;
        bus.data = 32'hFFFFFFFF;
        bus.len  = 6'd0;
        step();
        bus.load = 1'b0;
        check_vec("len0", status(), S_IDLE);
        step();
        check_vec("len0_hold", status(), S_IDLE);

        // Repeating 101; repeat_en wobble mid-pattern must not matter.
        bus.load = 1'b1;
        bus.data = 32'hA0000000;
        bus.len  = 6'd3;
        bus.repeat_en = 1'b1;
        step();
        bus.load = 1'b0;
        for (int unsigned i = 0; i < 15; i++) begin
            b = ((i % 3) != 1);
            check_vec("rep", status(), {28'b0, 3'b110, b});
            if (i == 7)  bus.repeat_en = 1'b0;
            if (i == 8)  bus.repeat_en = 1'b1;
            if (i == 12) bus.repeat_en = 1'b0;
            step();
        end
        check_vec("rep_done", status(), S_DONE);
        step();
        check_vec("rep_idle", status(), S_IDLE);

        // Reset at bit 10, with a simultaneous load that must be dropped.
        bus.load = 1'b1;
        bus.data = 32'h6DB4B255;
        bus.len  = 6'd32;
        step();
        bus.load = 1'b0;
        for (int unsigned i = 0; i < 10; i++) step();
        check_vec("bit10", status(), 32'b1101);
        rst = 1'b1;
        bus.load = 1'b1;
        bus.data = '1;
        bus.len  = 6'd5;
        step();
        check_vec("rst_abort", status(), S_IDLE);
        rst = 1'b0;
        bus.load = 1'b0;
        step();
        check_vec("rst_nodone", status(), S_IDLE);
        send_and_check("after_rst", 32'hC0000000, 6'd4, 4, 32'hC0000000, 1'b0, 1'b0);
        step();
        check_vec("after_rst_idle", status(), S_IDLE);

        // len clamp, with a mid-pattern load of all-ones that must be ignored.
        send_and_check("len40", 32'hF0F0F0F0, 6'd40, 32, 32'hF0F0F0F0, 1'b1, 1'b0);
        step();
        check_vec("len40_idle", status(), S_IDLE);

        // Single bit, then a load in the DONE cycle runs back-to-back.
        send_and_check("len1", 32'h80000000, 6'd1, 1, 32'h80000000, 1'b0, 1'b0);
        send_and_check("b2b", 32'h40000000, 6'd2, 2, 32'h40000000, 1'b0, 1'b0);
        step();
        check_vec("b2b_idle", status(), S_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, maximum pattern length in bits.
REQ-002 SHALL have parameter LW, default 6, width of len; must satisfy 2^LW > WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port load  input  1  request to start a new pattern.
REQ-006 SHALL have port data  input  WIDTH  pattern word, transmitted MSB first.
REQ-007 SHALL have port len  input  LW  number of bits to send, counted from data[WIDTH-1].
REQ-008 SHALL have port repeat_en  input  1  when high, restart the same pattern with no gap after the last bit.
REQ-009 SHALL have port dout  output  1  serial bit, the input to the team's sequence detector din.
REQ-010 SHALL have port dout_vld  output  1  dout carries a pattern bit this cycle.
REQ-011 SHALL have port busy  output  1  pattern in progress; load is ignored.
REQ-012 SHALL have port done  output  1  one-cycle pulse after a non-repeating pattern completes.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE; all outputs registered.
REQ-014 SHALL accept load only in IDLE or DONE, and only when len != 0; otherwise load has no effect.
REQ-015 SHALL clamp len > WIDTH to WIDTH at capture.
REQ-016 On an accepted load at edge k, SHALL capture data and the effective length, enter SHIFT, and present dout=data[WIDTH-1], dout_vld=1, busy=1 after edge k.
REQ-017 In SHIFT, SHALL present the next lower bit on each edge, giving exactly len consecutive valid bits with no bubbles.
REQ-018 At the edge after the last bit, with repeat_en=0, SHALL enter DONE with done=1, dout_vld=0, busy=0 and dout=0.
REQ-019 At the edge after the last bit, with repeat_en=1, SHALL reload the captured word, present its first bit immediately, stay in SHIFT, and keep done=0.
REQ-020 SHALL sample repeat_en only in the cycle the last bit is presented.
REQ-021 DONE SHALL last exactly one cycle, then go to IDLE; a load accepted in DONE behaves as in REQ-016, so the gap between patterns is one cycle.
REQ-022 SHALL ignore changes to data and len while busy; only the values captured at load are used.
REQ-023 SHALL drive dout=0 whenever dout_vld=0.
REQ-024 For len=1, SHALL emit a single valid bit followed by the DONE cycle.

Reset
REQ-025 When rst=1 at an edge, SHALL enter IDLE with dout=0, dout_vld=0, busy=0, done=0, shift register and counter cleared.
REQ-026 rst SHALL take priority over load, including reset mid-pattern; the aborted pattern produces no done pulse.
REQ-027 A load presented in the same cycle as rst SHALL be discarded.

Structure
REQ-028 SHALL place the state encodings (IDLE, SHIFT, DONE) and the default WIDTH/LW constants in shared package seq_gen_pkg.
REQ-029 SHALL implement the WIDTH-bit load/shift-left register as sub-module seq_gen_shreg (ports clk, rst, ld, sh, d, msb); the FSM and bit counter stay in seq_gen.
REQ-030 The bit counter SHALL be LW bits wide, count down from the effective len to 1, and never wrap.

Verification
REQ-031 SHALL cover: data=32'h6DB4B255, len=32, repeat_en=0 -> dout 0110_1101_1011_0100_1011_0010_0101_0101 over 32 consecutive valid cycles, then done=1 for one cycle.
REQ-032 SHALL cover: data=32'hA0000000, len=3, repeat_en=1 held -> dout 101101101... continuous, dout_vld never drops, done never asserts; dropping repeat_en ends after the current 101 with a done pulse.
REQ-033 SHALL cover: load pulsed mid-pattern with new data=32'hFFFFFFFF -> output unaffected; len=0 load in IDLE -> busy stays 0.
REQ-034 SHALL cover: rst=1 at bit 10 of a 32-bit pattern -> next cycle dout_vld=0, busy=0, done=0; a new load afterwards starts cleanly from the MSB.
REQ-035 SHALL cover: len=40 with WIDTH=32 -> exactly 32 bits emitted; len=1 data MSB=1 -> one bit 1, then done.
REQ-036 SHALL cover loopback: seq_gen dout driving seq_detect din, pattern as in REQ-031 -> detector flag pulses match a reference model cycle for cycle.
